// File: rtl/sdram_arb_pkg.sv
// Shared types and default widths for the two-port SDRAM command arbiter.
package sdram_arb_pkg;

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned DATA_W = 16;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } sdram_cmd_t;

  typedef enum logic {
    PORT_CPU = 1'b0,
    PORT_VID = 1'b1
  } port_id_t;

endpackage

// File: rtl/arb_tag_fifo.sv
// In-order queue of read owners; one entry per read outstanding in the manager.
module arb_tag_fifo
  import sdram_arb_pkg::*;
#(
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  port_id_t                   i_din,
  input  logic                       i_pop,
  output port_id_t                   o_dout,
  output logic                       o_empty,
  output logic                       o_full,
  output logic [$clog2(DEPTH+1)-1:0] o_count
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH+1);

  port_id_t        r_mem [DEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;
  logic            w_push;
  logic            w_pop;

  assign o_empty = (r_count == {CW{1'b0}});
  assign o_full  = (r_count == CW'(DEPTH));
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_dout  = r_mem[r_rd_ptr];
  assign o_count = r_count;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= {PW{1'b0}};
      r_rd_ptr <= {PW{1'b0}};
      r_count  <= {CW{1'b0}};
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= PORT_CPU;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_din;
        r_wr_ptr        <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/sdram_port_arbiter.sv
// Round-robin sharing of the SDRAM manager command port between CPU (port 0)
// and video (port 1), with in-order routing of read returns to their owner.
module sdram_port_arbiter #(
  parameter int unsigned ADDR_W    = sdram_arb_pkg::ADDR_W,
  parameter int unsigned DATA_W    = sdram_arb_pkg::DATA_W,
  parameter int unsigned TAG_DEPTH = 8
) (
  input  logic                           clk100_0ds,
  input  logic                           rst_n,
  input  logic                           p0_req,
  input  logic                           p0_we,
  input  logic [ADDR_W-1:0]              p0_addr,
  input  logic [DATA_W-1:0]              p0_wdata,
  output logic                           p0_ack,
  output logic                           p0_rd_valid,
  output logic [DATA_W-1:0]              p0_rdata,
  input  logic                           p1_req,
  input  logic                           p1_we,
  input  logic [ADDR_W-1:0]              p1_addr,
  input  logic [DATA_W-1:0]              p1_wdata,
  output logic                           p1_ack,
  output logic                           p1_rd_valid,
  output logic [DATA_W-1:0]              p1_rdata,
  output logic [ADDR_W-1:0]              mgr_addr,
  output logic [DATA_W-1:0]              mgr_data,
  output logic                           mgr_rw,
  output logic                           mgr_wrreq,
  input  logic                           mgr_full,
  input  logic                           mgr_rd_valid,
  input  logic [DATA_W-1:0]              mgr_rd_data,
  output logic [$clog2(TAG_DEPTH+1)-1:0] reads_outstanding,
  output logic                           orphan_err
);

  import sdram_arb_pkg::*;

  logic              r_stage_valid;
  logic              r_stage_rw;
  logic [ADDR_W-1:0] r_stage_addr;
  logic [DATA_W-1:0] r_stage_data;
  port_id_t          r_last_grant;
  logic              r_p0_rd_valid;
  logic              r_p1_rd_valid;
  logic [DATA_W-1:0] r_p0_rdata;
  logic [DATA_W-1:0] r_p1_rdata;
  logic              r_orphan;

  logic              w_drain;
  logic              w_stage_free;
  logic              w_elig0;
  logic              w_elig1;
  logic              w_gnt0;
  logic              w_gnt1;
  logic              w_win_rw;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_data;
  logic              w_tag_push;
  logic              w_tag_pop;
  logic              w_tag_empty;
  logic              w_tag_full;
  port_id_t          w_tag_head;

  assign w_drain      = r_stage_valid & ~mgr_full;
  assign w_stage_free = ~r_stage_valid | w_drain;
  assign w_tag_push   = (w_gnt0 & ~p0_we) | (w_gnt1 & ~p1_we);
  assign w_tag_pop    = mgr_rd_valid & ~w_tag_empty;

  // Tag-full is the registered occupancy, so a pop this cycle frees nothing yet.
  always_comb begin
    w_elig0    = p0_req & w_stage_free & (p0_we | ~w_tag_full);
    w_elig1    = p1_req & w_stage_free & (p1_we | ~w_tag_full);
    w_gnt0     = w_elig0 & (~w_elig1 | (r_last_grant == PORT_VID));
    w_gnt1     = w_elig1 & (~w_elig0 | (r_last_grant == PORT_CPU));
    w_win_rw   = p0_we;
    w_win_addr = p0_addr;
    w_win_data = p0_wdata;
    if (w_gnt1) begin
      w_win_rw   = p1_we;
      w_win_addr = p1_addr;
      w_win_data = p1_wdata;
    end else begin
      w_win_rw   = p0_we;
      w_win_addr = p0_addr;
      w_win_data = p0_wdata;
    end
  end

  always_ff @(posedge clk100_0ds or negedge rst_n) begin
    if (!rst_n) begin
      r_stage_valid <= 1'b0;
      r_stage_rw    <= 1'b0;
      r_stage_addr  <= {ADDR_W{1'b0}};
      r_stage_data  <= {DATA_W{1'b0}};
      r_last_grant  <= PORT_VID;
    end else begin
      if (w_gnt0 | w_gnt1) begin
        r_stage_valid <= 1'b1;
        r_stage_rw    <= w_win_rw;
        r_stage_addr  <= w_win_addr;
        r_stage_data  <= w_win_data;
        r_last_grant  <= w_gnt1 ? PORT_VID : PORT_CPU;
      end else if (w_drain) begin
        r_stage_valid <= 1'b0;
      end
    end
  end

  // Return path: the popped tag selects which port sees the pulse next cycle.
  always_ff @(posedge clk100_0ds or negedge rst_n) begin
    if (!rst_n) begin
      r_p0_rd_valid <= 1'b0;
      r_p1_rd_valid <= 1'b0;
      r_p0_rdata    <= {DATA_W{1'b0}};
      r_p1_rdata    <= {DATA_W{1'b0}};
      r_orphan      <= 1'b0;
    end else begin
      r_p0_rd_valid <= w_tag_pop & (w_tag_head == PORT_CPU);
      r_p1_rd_valid <= w_tag_pop & (w_tag_head == PORT_VID);
      if (w_tag_pop & (w_tag_head == PORT_CPU)) r_p0_rdata <= mgr_rd_data;
      if (w_tag_pop & (w_tag_head == PORT_VID)) r_p1_rdata <= mgr_rd_data;
      if (mgr_rd_valid & w_tag_empty) r_orphan <= 1'b1;
    end
  end

  arb_tag_fifo #(
    .DEPTH (TAG_DEPTH)
  ) u_tag_fifo (
    .clk     (clk100_0ds),
    .rst_n   (rst_n),
    .i_push  (w_tag_push),
    .i_din   (w_gnt1 ? PORT_VID : PORT_CPU),
    .i_pop   (w_tag_pop),
    .o_dout  (w_tag_head),
    .o_empty (w_tag_empty),
    .o_full  (w_tag_full),
    .o_count (reads_outstanding)
  );

  assign p0_ack      = w_gnt0;
  assign p1_ack      = w_gnt1;
  assign mgr_wrreq   = w_drain;
  assign mgr_rw      = r_stage_rw;
  assign mgr_addr    = r_stage_addr;
  assign mgr_data    = r_stage_data;
  assign p0_rd_valid = r_p0_rd_valid;
  assign p1_rd_valid = r_p1_rd_valid;
  assign p0_rdata    = r_p0_rdata;
  assign p1_rdata    = r_p1_rdata;
  assign orphan_err  = r_orphan;

endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Scoreboard bench: acked commands and read returns are queued as expectations
// and retired when the arbiter presents them to the manager or to a port.
module tb_sdram_port_arbiter;

  typedef struct {
    logic        rw;
    logic [19:0] addr;
    logic [15:0] data;
  } cmd_t;

  typedef struct {
    bit          port;
    logic [15:0] data;
  } ret_t;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        p0_req = 1'b0, p0_we = 1'b0, p1_req = 1'b0, p1_we = 1'b0;
  logic [19:0] p0_addr = 20'h0, p1_addr = 20'h0;
  logic [15:0] p0_wdata = 16'h0, p1_wdata = 16'h0;
  logic        p0_ack, p1_ack, p0_rd_valid, p1_rd_valid;
  logic [15:0] p0_rdata, p1_rdata;
  logic [19:0] mgr_addr;
  logic [15:0] mgr_data;
  logic        mgr_rw, mgr_wrreq;
  logic        mgr_full = 1'b0;
  logic        mgr_rd_valid = 1'b0;
  logic [15:0] mgr_rd_data = 16'h0;
  logic [3:0]  reads_outstanding;
  logic        orphan_err;

  cmd_t cmdq[$];
  ret_t retq[$];
  bit   tagq[$];
  bit   orphan_m = 1'b0;
  int   n_checks = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sdram_port_arbiter dut (
    .clk100_0ds(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_ack(p0_ack), .p0_rd_valid(p0_rd_valid), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rd_valid(p1_rd_valid), .p1_rdata(p1_rdata),
    .mgr_addr(mgr_addr), .mgr_data(mgr_data), .mgr_rw(mgr_rw),
    .mgr_wrreq(mgr_wrreq), .mgr_full(mgr_full), .mgr_rd_valid(mgr_rd_valid),
    .mgr_rd_data(mgr_rd_data), .reads_outstanding(reads_outstanding),
    .orphan_err(orphan_err)
  );

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic monitor();
    cmd_t c;
    ret_t r;
    check_eq("wrreq", 32'(mgr_wrreq), 32'((cmdq.size() != 0) && !mgr_full));
    if (mgr_wrreq && cmdq.size() != 0) begin
      c = cmdq.pop_front();
      check_eq("mgr_rw", 32'(mgr_rw), 32'(c.rw));
      check_eq("mgr_addr", 32'(mgr_addr), 32'(c.addr));
      check_eq("mgr_data", 32'(mgr_data), 32'(c.data));
    end
    if (retq.size() != 0) begin
      r = retq.pop_front();
      check_eq("p0_rd_valid", 32'(p0_rd_valid), 32'(r.port == 1'b0));
      check_eq("p1_rd_valid", 32'(p1_rd_valid), 32'(r.port == 1'b1));
      check_eq("rdata", 32'(r.port ? p1_rdata : p0_rdata), 32'(r.data));
    end else begin
      check_eq("p0_rd_idle", 32'(p0_rd_valid), 32'd0);
      check_eq("p1_rd_idle", 32'(p1_rd_valid), 32'd0);
    end
    check_eq("outstanding", 32'(reads_outstanding), 32'(tagq.size()));
    check_eq("orphan_err", 32'(orphan_err), 32'(orphan_m));
  endtask

  // One clock: check outputs mid-cycle, record what this cycle should cause.
  task automatic step(input bit e0, input bit e1);
    ret_t r;
    @(negedge clk);
    monitor();
    check_eq("p0_ack", 32'(p0_ack), 32'(e0));
    check_eq("p1_ack", 32'(p1_ack), 32'(e1));
    if (mgr_rd_valid && rst_n) begin
      if (tagq.size() == 0) orphan_m = 1'b1;
      else begin
        r.port = tagq.pop_front();
        r.data = mgr_rd_data;
        retq.push_back(r);
      end
    end
    if (e0) begin
      cmdq.push_back('{p0_we, p0_addr, p0_wdata});
      if (!p0_we) tagq.push_back(1'b0);
    end
    if (e1) begin
      cmdq.push_back('{p1_we, p1_addr, p1_wdata});
      if (!p1_we) tagq.push_back(1'b1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero_outputs();
    check_eq("rst_mgr_addr", 32'(mgr_addr), 32'd0);
    check_eq("rst_mgr_data", 32'(mgr_data), 32'd0);
    check_eq("rst_mgr_rw", 32'(mgr_rw), 32'd0);
    check_eq("rst_p0_rdata", 32'(p0_rdata), 32'd0);
    check_eq("rst_p1_rdata", 32'(p1_rdata), 32'd0);
  endtask

  initial begin
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check_zero_outputs();
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    // Tie between continuous writers: port 0 takes the first tie.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 20'h0A000; p0_wdata = 16'hA000;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 20'h0B000; p1_wdata = 16'hB000;
    for (int i = 0; i < 4; i++) begin
      step(i % 2 == 0, i % 2 == 1);
      if (i % 2 == 0) begin p0_addr = p0_addr + 20'd1; p0_wdata = p0_wdata + 16'd1; end
      else begin p1_addr = p1_addr + 20'd1; p1_wdata = p1_wdata + 16'd1; end
    end
    p0_req = 1'b0; p1_req = 1'b0;
    step(1'b0, 1'b0);

    // Single read on port 0.
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 20'h00010;
    step(1'b1, 1'b0);
    p0_req = 1'b0;
    step(1'b0, 1'b0);
    mgr_rd_valid = 1'b1; mgr_rd_data = 16'hBEEF;
    step(1'b0, 1'b0);
    mgr_rd_valid = 1'b0;
    step(1'b0, 1'b0);

    // Interleaved reads from both ports.
    p1_req = 1'b1; p1_we = 1'b0; p1_addr = 20'h00100;
    step(1'b0, 1'b1);
    p1_req = 1'b0; p0_req = 1'b1; p0_we = 1'b0; p0_addr = 20'h00200;
    step(1'b1, 1'b0);
    p0_req = 1'b0; p1_req = 1'b1; p1_addr = 20'h00300;
    step(1'b0, 1'b1);
    p1_req = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      mgr_rd_valid = 1'b1; mgr_rd_data = 16'(i * 16'h1111);
      step(1'b0, 1'b0);
    end
    mgr_rd_valid = 1'b0;
    step(1'b0, 1'b0);

    // Tag queue full blocks reads but not writes.
    p0_req = 1'b1; p0_we = 1'b0;
    for (int i = 0; i < 8; i++) begin
      p0_addr = 20'h00400 + 20'(i);
      step(1'b1, 1'b0);
    end
    p0_addr = 20'h00408;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 20'h0C000; p1_wdata = 16'hC0DE;
    step(1'b0, 1'b1);
    p1_req = 1'b0;
    step(1'b0, 1'b0);
    mgr_rd_valid = 1'b1; mgr_rd_data = 16'h5000;
    step(1'b0, 1'b0);
    mgr_rd_valid = 1'b0;
    step(1'b1, 1'b0);
    p0_req = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      mgr_rd_valid = 1'b1; mgr_rd_data = 16'h5000 + 16'(i);
      step(1'b0, 1'b0);
    end
    mgr_rd_valid = 1'b0;
    step(1'b0, 1'b0);

    // Backpressure holds the stage and suppresses acks.
    p0_req = 1'b1; p0_we = 1'b1; p0_addr = 20'h0D000; p0_wdata = 16'hD000;
    step(1'b1, 1'b0);
    mgr_full = 1'b1;
    p0_addr = 20'h0D001; p0_wdata = 16'hD001;
    p1_req = 1'b1; p1_we = 1'b1; p1_addr = 20'h0E000; p1_wdata = 16'hE000;
    for (int i = 0; i < 5; i++) step(1'b0, 1'b0);
    mgr_full = 1'b0;
    step(1'b0, 1'b1);
    p1_req = 1'b0;
    step(1'b1, 1'b0);
    p0_req = 1'b0;
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);

    // Orphan return, then reset with reads outstanding.
    mgr_rd_valid = 1'b1; mgr_rd_data = 16'hDEAD;
    step(1'b0, 1'b0);
    mgr_rd_valid = 1'b0;
    step(1'b0, 1'b0);
    p0_req = 1'b1; p0_we = 1'b0; p0_addr = 20'h00600;
    step(1'b1, 1'b0);
    p0_req = 1'b0; p1_req = 1'b1; p1_we = 1'b0; p1_addr = 20'h00700;
    step(1'b0, 1'b1);
    p1_req = 1'b0; p0_req = 1'b1; p0_addr = 20'h00601;
    step(1'b1, 1'b0);
    p0_req = 1'b0;
    step(1'b0, 1'b0);
    rst_n = 1'b0;
    cmdq.delete(); retq.delete(); tagq.delete(); orphan_m = 1'b0;
    step(1'b0, 1'b0);
    check_zero_outputs();
    rst_n = 1'b1;
    step(1'b0, 1'b0);

    check_eq("cmdq_empty", 32'(cmdq.size()), 32'd0);
    check_eq("retq_empty", 32'(retq.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
